// File: rtl/y86_pkg.sv
// Shared Y86 types for the write-back path.
// Register id, data word and queued write-back entry.
package y86_pkg;

  typedef logic [3:0]  regid_t;
  typedef logic [63:0] word_t;

  localparam regid_t REG_NONE = 4'hF;

  typedef struct packed {
    regid_t dst;
    word_t  val;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// 2-push / 1-pop circular buffer of write-back entries.
// Ports: push count + two entries, pop; exposes entries, valid mask, head, count.
module regfile_wb_fifo
  import y86_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               i_push_n,
  input  wb_entry_t                i_d0,
  input  wb_entry_t                i_d1,
  input  logic                     i_pop,
  output wb_entry_t                o_mem [DEPTH],
  output logic [DEPTH-1:0]         o_valid,
  output wb_entry_t                o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t         r_mem [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic              w_pop;

  assign w_pop = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail  <= r_tail + PW'(i_push_n);
      r_head  <= r_head + PW'(w_pop);
      r_count <= r_count + CW'(i_push_n) - CW'(w_pop);
    end
  end

  // Contents need no reset: validity comes from head/count.
  always_ff @(posedge clk) begin
    if (i_push_n != 2'd0)
      r_mem[r_tail] <= i_d0;
    if (i_push_n == 2'd2)
      r_mem[r_tail + PW'(1)] <= i_d1;
  end

  // Slot i is occupied when its distance from head is below count.
  always_comb begin
    logic [PW-1:0] w_off;
    o_valid = '0;
    w_off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off      = PW'(i) - r_head;
      o_valid[i] = {1'b0, w_off} < r_count;
    end
  end

  assign o_mem   = r_mem;
  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Y86 write-back arbiter: queues E/M writes, drains one per cycle, flags busy srcs.
// Ports: wbE_*/wbM_* requests, rf_* write port, srcA/B -> busyA/B, count, overflow.
module regfile_wb_arbiter
  import y86_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wbE_valid,
  input  logic [3:0]              wbE_dst,
  input  logic [W-1:0]            wbE_val,
  input  logic                    wbM_valid,
  input  logic [3:0]              wbM_dst,
  input  logic [W-1:0]            wbM_val,
  output logic                    wb_ready,
  output logic                    rf_we,
  output logic [3:0]              rf_waddr,
  output logic [W-1:0]            rf_wdata,
  input  logic                    rf_ready,
  input  logic [3:0]              srcA,
  input  logic [3:0]              srcB,
  output logic                    busyA,
  output logic                    busyB,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);

  logic               w_effE;
  logic               w_effM;
  logic [1:0]         w_push_n;
  wb_entry_t          w_d0;
  wb_entry_t          w_d1;
  wb_entry_t          w_mem [DEPTH];
  wb_entry_t          w_head;
  logic [DEPTH-1:0]   w_valid;
  logic               r_ovf;

  assign w_effE = wbE_valid && (wbE_dst != REG_NONE);
  assign w_effM = wbM_valid && (wbM_dst != REG_NONE);

  // Headroom for a full pair; a same-cycle pop is not credited.
  assign wb_ready = (32'(count) + 32'd2) <= 32'(DEPTH);

  // Compact to slot 0 first so E lands ahead of M.
  always_comb begin
    w_d0.dst = wbM_dst;
    w_d0.val = word_t'(wbM_val);
    w_d1.dst = wbM_dst;
    w_d1.val = word_t'(wbM_val);
    if (w_effE) begin
      w_d0.dst = wbE_dst;
      w_d0.val = word_t'(wbE_val);
    end
  end

  assign w_push_n = wb_ready ? (2'(w_effE) + 2'(w_effM)) : 2'd0;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_ovf <= 1'b0;
    else if (!wb_ready && (w_effE || w_effM))
      r_ovf <= 1'b1;
  end

  assign overflow = r_ovf;

  regfile_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push_n (w_push_n),
    .i_d0     (w_d0),
    .i_d1     (w_d1),
    .i_pop    (rf_we && rf_ready),
    .o_mem    (w_mem),
    .o_valid  (w_valid),
    .o_head   (w_head),
    .o_count  (count)
  );

  assign rf_we    = (count != '0);
  assign rf_waddr = rf_we ? w_head.dst : 4'h0;
  assign rf_wdata = rf_we ? W'(w_head.val) : '0;

  always_comb begin
    busyA = 1'b0;
    busyB = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && (w_mem[i].dst == srcA))
        busyA = 1'b1;
      if (w_valid[i] && (w_mem[i].dst == srcB))
        busyB = 1'b1;
    end
    if (srcA == REG_NONE)
      busyA = 1'b0;
    if (srcB == REG_NONE)
      busyB = 1'b0;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the Y86 register file. It accepts up to two write-back requests per cycle (E-port: `dstE`/`valE`; M-port: `dstM`/`valM`) and buffers them in a small in-order queue. It drains the queue into the single physical write port of the register file, one write per cycle, and reports which decode source registers still have writes in flight so the hazard logic can stall.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, ≥ 2.
- `W`, 64: data width.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `wbE_valid` in 1: E-port write request.
- `wbE_dst` in 4: E-port destination; 4'hF means no register.
- `wbE_val` in W: E-port data.
- `wbM_valid` in 1: M-port write request.
- `wbM_dst` in 4: M-port destination; 4'hF means no register.
- `wbM_val` in W: M-port data.
- `wb_ready` out 1: queue can absorb two entries this cycle.
- `rf_we` out 1: register-file write strobe.
- `rf_waddr` out 4: register-file write address.
- `rf_wdata` out W: register-file write data.
- `rf_ready` in 1: register file accepts the presented write this cycle.
- `srcA` in 4: decode source A.
- `srcB` in 4: decode source B.
- `busyA` out 1: `srcA` has a pending write in the queue.
- `busyB` out 1: `srcB` has a pending write in the queue.
- `count` out $clog2(DEPTH)+1: occupied entries.
- `overflow` out 1: sticky; a request was dropped.

## Operation
- **Effective request:**
  - A port request is effective when `valid=1` and `dst != 4'hF`.
  - `valid=1` with `dst=4'hF` is a silent no-op: nothing is enqueued and `overflow` is unaffected.
- **Enqueue (`wb_ready=1`):**
  - Effective requests are written at the tail in the order E then M.
  - This ordering makes M the later write. For equal destinations (popq %rsp), the M value lands last and wins.
  - With a single effective request, only one entry is consumed.
- **Enqueue (`wb_ready=0`):**
  - Every effective request is dropped.
  - `overflow` sets to 1 at that edge and holds until reset.
- **`wb_ready`:** `= (DEPTH - count) >= 2`. It is computed from the registered `count` only; a same-cycle pop is not credited.
- **Drain:**
  - When `count>0`: `rf_we=1` and `rf_waddr`/`rf_wdata` present the head entry. All three are combinational from the head.
  - The head pops at the edge where `rf_we && rf_ready`.
  - With `rf_ready=0`, the head and the outputs hold stable.
  - When `count=0`: `rf_we=0`, and `rf_waddr`/`rf_wdata` are 0.
- **Simultaneous push and pop:** allowed in the same edge.
  - `count` next = `count` + pushes − pop.
  - Pushes are 0, 1 or 2; pop is 0 or 1.
- **Pointers:** head and tail wrap modulo `DEPTH`.
- **Scoreboard:**
  - `busyX=1` iff any occupied entry has `dst == srcX`.
  - Combinational over the registered queue contents; same-cycle requests are not visible.
  - `srcX=4'hF` always gives `busyX=0`.

## Timing
- Reset (`rst_n=0` at an edge):
  - `count=0`, head and tail pointers = 0, `overflow=0`.
  - Consequently `rf_we=0`, `busyA=busyB=0`, `wb_ready=1`.
  - Queue contents are discarded, including in-flight entries (reset mid-drain loses them).
  - Requests presented in the reset cycle are ignored.
- Latency:
  - A request accepted at edge N appears on `rf_we` during cycle N+1.
  - With `rf_ready=1`, it is written at edge N+1.
  - The second of a pair is written at edge N+2.
- Throughput: one write per cycle sustained.
  - Sustained dual requests fill the queue.
  - `wb_ready` then drops and upstream must stall.
- `busyX` rises the cycle after enqueue. It falls the cycle after the last matching entry pops.

## Structure
- Package `y86_pkg`:
  - `REG_NONE = 4'hF`.
  - `regid_t` (4-bit).
  - `word_t` (64-bit).
  - `wb_entry_t` struct {`regid_t dst`; `word_t val`}.
- Sub-module `regfile_wb_fifo`:
  - 2-push/1-pop circular buffer of `wb_entry_t`.
  - Exposes the entry array, valid mask and `count`.
- Top level holds:
  - effective-request filtering and E/M ordering;
  - `wb_ready` and `overflow`;
  - the scoreboard comparators.

## Test plan
- **Single write.** Reset, then `wbE_valid=1`, `wbE_dst=2`, `wbE_val=0x11` for one cycle, `rf_ready=1`.
  - Next cycle: `rf_we=1`, `rf_waddr=2`, `rf_wdata=0x11`, `busyA=1` with `srcA=2`.
  - Cycle after: `count=0`, `busyA=0`.
- **Same-destination ordering.** E `dst=4` `val=0x8`, M `dst=4` `val=0x55` in the same cycle.
  - Writes are (4, 0x8) then (4, 0x55) on consecutive cycles.
  - `count` goes 2→1→0.
- **No-register requests.** E `dst=F`, M `dst=3` `val=7`.
  - Only one entry is enqueued (`count=1`).
  - `overflow` stays 0 and `busyB=0` for `srcB=F`.
- **Backpressure.** `rf_ready=0`; issue two dual requests.
  - `count=4` and `wb_ready=0`, with outputs stable at the first entry.
  - A third request is dropped and sets `overflow=1`.
  - Release `rf_ready`: four writes in order, then `wb_ready=1`, with `overflow` still 1.
- **Wrap-around.** Interleave single pushes and pops for 10 cycles with dsts 0..9.
  - Writes emerge in order with correct data across the pointer wrap.
- **Reset mid-drain.** `count=3`, assert `rst_n=0` for one edge.
  - Then `rf_we=0`, `count=0`, `busy*=0`, `overflow=0`, `wb_ready=1`.
  - No stale entry is written afterwards.
